des128_round_iterator: RTL and testbench
========================================

Name: des128_round_iterator

Overview:
- Sequential Feistel round controller for the 128-bit expanded DES datapath. Sits directly downstream of the XOR_FUNCTION stage.
- Holds the L/R 64-bit half-block registers and drives the current R (to the F-function) and L (to the XOR stage).
- Latches the XOR result as the next R each round, iterating NUM_ROUNDS rounds per block.
- Valid/ready handshakes on input and output; exports the round index so the subkey generator can select K.

Parameters:
HALF_W, 64, width of each half-block (L and R)
NUM_ROUNDS, 16, Feistel rounds per block; must be >= 1
RND_W, 4, round-index width; must satisfy 2^RND_W >= NUM_ROUNDS

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  data_in holds a block to encrypt/decrypt
in_ready  output  1  block can accept a new input
data_in  input  2*HALF_W  input block; [127:64]=L0, [63:0]=R0
l_out  output  HALF_W  current L register, to XOR stage L0 input
r_out  output  HALF_W  current R register, to F-function
round_idx  output  RND_W  current round number 0..NUM_ROUNDS-1, to subkey select
xor_in  input  HALF_W  XOR stage result F(R,K)^L for the current round (combinational from l_out/r_out/round_idx)
out_valid  output  1  data_out holds a finished block
out_ready  input  1  downstream accepts data_out
data_out  output  2*HALF_W  result {R_final, L_final} (pre-output swap)
busy  output  1  high while in RUN

Behaviour:
- States: IDLE, RUN, DONE (2-bit encoded).
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE; L=0, R=0, round_idx=0.
  - in_ready=1, out_valid=0, busy=0; data_out=0.
  - Reset mid-RUN or mid-DONE discards the block; no partial output.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: L<=data_in[127:64], R<=data_in[63:0], round_idx<=0, go RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle: L<=R, R<=xor_in.
  - If round_idx==NUM_ROUNDS-1: go DONE and round_idx<=0. Otherwise round_idx<=round_idx+1.
- DONE:
  - out_valid=1; data_out={R,L} (final swap undone).
  - L, R and data_out hold stable while out_ready=0.
  - On out_valid&&out_ready: go IDLE.
  - in_ready stays 0 in DONE; no input/output overlap. A new block is accepted no earlier than the cycle after the output handshake.
- Latency:
  - Accept edge at cycle 0; the round-k update happens at the edge ending cycle k (cycle 1 = round 0).
  - out_valid=1 during cycle NUM_ROUNDS+1, i.e. 17 cycles after the accept edge for NUM_ROUNDS=16.
  - Throughput is one block per NUM_ROUNDS+2 cycles, assuming out_ready=1.
- l_out, r_out and round_idx are direct register outputs; no combinational path from xor_in to any output.
- round_idx never exceeds NUM_ROUNDS-1; no wrap beyond it.
- in_valid while not in IDLE is ignored; the upstream source must hold data until in_ready.
- xor_in is sampled only in RUN; its value in other states is don't-care.
- Decryption uses the same block; only the subkey order, driven externally from round_idx, differs.

Decomposition:
- Shared package des128_pkg holds:
  - HALF_W=64, NUM_ROUNDS=16, RND_W=4.
  - State typedef {IDLE, RUN, DONE}.
  - Block typedef of 2*HALF_W bits.
- No sub-module; the XOR stage and the F-function are instantiated alongside at the top level, not inside this block.

Test Plan:
- Null-F round trip: bench drives xor_in=l_out (F=0); data_in=128'h0123456789ABCDEF_FEDCBA9876543210 -> after 16 rounds data_out=128'hFEDCBA9876543210_0123456789ABCDEF; out_valid rises exactly 17 cycles after the accept edge.
- Round index and swap: bench F=R (xor_in=r_out^l_out); data_in={64'h1, 64'h2} -> round_idx steps 0..15 one per cycle; check L/R each cycle against a reference model; data_out matches model.
- Output backpressure: hold out_ready=0 for 5 cycles after out_valid -> data_out stable, in_ready=0, in_valid ignored; release -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst at round 7 -> next cycle state IDLE, l_out=r_out=0, round_idx=0, out_valid=0; a fresh block then completes correctly.
- Back-to-back blocks: in_valid held high with out_ready=1 and two distinct blocks -> second accepted the cycle after the first output handshake; both results correct; 18 cycles per block.
- Input ignored while busy: change data_in and pulse in_valid during RUN -> result unaffected, in_ready stays 0.

Source files
------------

// File: rtl/des128_pkg.sv
// Shared constants and types for the 128-bit expanded DES datapath.
package des128_pkg;

    localparam int HALF_W     = 64;
    localparam int NUM_ROUNDS = 16;
    localparam int RND_W      = 4;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    typedef logic [2*HALF_W-1:0] block_t;

endpackage

// File: rtl/des128_round_iterator.sv
// Feistel round controller: holds L/R, feeds the F/XOR stages and latches
// the XOR result as the next R, one round per clock.
module des128_round_iterator #(
    parameter int HALF_W     = des128_pkg::HALF_W,
    parameter int NUM_ROUNDS = des128_pkg::NUM_ROUNDS,
    parameter int RND_W      = des128_pkg::RND_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   data_in,
    output logic [HALF_W-1:0]     l_out,
    output logic [HALF_W-1:0]     r_out,
    output logic [RND_W-1:0]      round_idx,
    input  logic [HALF_W-1:0]     xor_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*HALF_W-1:0]   data_out,
    output logic                  busy,
    output logic [1:0]            fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE and out_valid only in DONE, so input and
    // output transfers never overlap; both are pure state decodes.

    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS - 1);

    des128_pkg::state_t state;
    logic [HALF_W-1:0]  l_q;
    logic [HALF_W-1:0]  r_q;
    logic [RND_W-1:0]   rnd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= des128_pkg::IDLE;
            l_q   <= '0;
            r_q   <= '0;
            rnd_q <= '0;
        end else begin
            case (state)
                des128_pkg::IDLE: begin
                    if (in_valid) begin
                        l_q   <= data_in[2*HALF_W-1:HALF_W];
                        r_q   <= data_in[HALF_W-1:0];
                        rnd_q <= '0;
                        state <= des128_pkg::RUN;
                    end
                end
                des128_pkg::RUN: begin
                    l_q <= r_q;
                    r_q <= xor_in;
                    if (rnd_q == LAST_ROUND) begin
                        rnd_q <= '0;
                        state <= des128_pkg::DONE;
                    end else begin
                        rnd_q <= rnd_q + RND_W'(1);
                    end
                end
                des128_pkg::DONE: begin
                    if (out_ready) state <= des128_pkg::IDLE;
                end
                default: state <= des128_pkg::IDLE;
            endcase
        end
    end

    assign in_ready  = (state == des128_pkg::IDLE);
    assign busy      = (state == des128_pkg::RUN);
    assign out_valid = (state == des128_pkg::DONE);
    assign l_out     = l_q;
    assign r_out     = r_q;
    assign round_idx = rnd_q;
    assign fsm_state = state;
    // The last round leaves the halves swapped; presenting {R,L} undoes it.
    assign data_out  = out_valid ? {r_q, l_q} : '0;

endmodule

// File: tb/tb_des128_round_iterator.sv
// Self-checking bench for des128_round_iterator with a block-level Feistel model.
module tb_des128_round_iterator;

    localparam int NR = 16;

    logic         clk = 0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [63:0]  l_out;
    logic [63:0]  r_out;
    logic [3:0]   round_idx;
    logic [63:0]  xor_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;
    logic [1:0]   fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    int fmode = 0;
    logic [63:0] keys [NR];
    logic [127:0] exp_q[$];

    des128_round_iterator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .l_out(l_out), .r_out(r_out), .round_idx(round_idx),
        .xor_in(xor_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // External round function: mode 0 is F=0, mode 1 is F=R, otherwise keyed mix.
    function automatic logic [63:0] f_func(input logic [63:0] r, input int k, input int mode);
        if (mode == 0) return 64'h0;
        if (mode == 1) return r;
        return ((r ^ keys[k]) * 64'h9E3779B97F4A7C15) ^ {r[12:0], r[63:13]};
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] d, input int mode);
        logic [63:0] l, r, t;
        l = d[127:64];
        r = d[63:0];
        for (int k = 0; k < NR; k++) begin
            t = r;
            r = l ^ f_func(r, k, mode);
            l = t;
        end
        return {r, l};
    endfunction

    assign xor_in = l_out ^ f_func(r_out, int'(round_idx), fmode);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model: phase -1 idle, 0..NR-1 running that round, NR done.
    int          phase = -1;
    bit          model_on = 0;
    logic [63:0] ml = '0, mr = '0, mt;

    always @(posedge clk) begin
        if (rst) begin
            phase = -1; ml = '0; mr = '0;
            exp_q.delete();
            model_on = 1;
        end else if (model_on) begin
            if (phase == -1) begin
                if (in_valid) begin
                    ml = data_in[127:64];
                    mr = data_in[63:0];
                    phase = 0;
                    exp_q.push_back(ref_block(data_in, fmode));
                end
            end else if (phase < NR) begin
                mt = mr;
                mr = ml ^ f_func(mr, phase, fmode);
                ml = mt;
                phase++;
            end else if (out_ready) begin
                phase = -1;
                void'(exp_q.pop_front());
            end
        end
        #1;
        if (model_on) begin
            chk("in_ready", 128'(in_ready), 128'(phase == -1));
            chk("busy", 128'(busy), 128'(phase >= 0 && phase < NR));
            chk("out_valid", 128'(out_valid), 128'(phase == NR));
            chk("l_out", 128'(l_out), 128'(ml));
            chk("r_out", 128'(r_out), 128'(mr));
            chk("round_idx", 128'(round_idx), 128'((phase >= 0 && phase < NR) ? phase : 0));
            if (phase == NR && exp_q.size() > 0) chk("data_out", data_out, exp_q[0]);
        end
    end

    task automatic send(input logic [127:0] d);
        bit ok = 0;
        @(negedge clk);
        data_in  = d;
        in_valid = 1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("send_timeout", 128'(0), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
    endtask

    // Called right after send(); counts cycles from the accept edge to out_valid.
    task automatic wait_out(input bit rnd_bp, output int lat, output logic [127:0] d);
        bit ok = 0;
        lat = 1;
        d = '0;
        for (int i = 2; i < 300; i++) begin
            @(negedge clk);
            out_ready = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && lat == 1) lat = i;
            if (out_valid && out_ready) begin
                d = data_out; ok = 1;
                @(posedge clk);
                break;
            end
        end
        if (!ok) chk("out_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a, b, c, d, d0;
        logic [127:0] got [2];
        int lat, cyc, acc, outs, acc_cyc [2];

        foreach (keys[i]) keys[i] = {$urandom, $urandom};
        rst = 1; in_valid = 0; out_ready = 1; data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_data_out", data_out, 128'(0));
        chk("rst_lr", {l_out, r_out}, 128'(0));
        chk("rst_round", 128'(round_idx), 128'(0));
        chk("rst_state", 128'(fsm_state), 128'(des128_pkg::IDLE));
        rst = 0;

        // Null F: 16 swaps return the halves to place, so output is {R0,L0}.
        fmode = 0;
        a = 128'h0123456789ABCDEF_FEDCBA9876543210;
        chk("model_nullf", ref_block(a, 0), 128'hFEDCBA9876543210_0123456789ABCDEF);
        send(a);
        wait_out(0, lat, d);
        chk("nullf_data", d, 128'hFEDCBA9876543210_0123456789ABCDEF);
        chk("nullf_latency", 128'(lat), 128'(17));

        // F=R: (L,R) cycles with period 3; after 16 rounds (L,R)=(2,3).
        fmode = 1;
        a = {64'h1, 64'h2};
        chk("model_f_r", ref_block(a, 1), {64'h3, 64'h2});
        send(a);
        wait_out(0, lat, d);
        chk("f_r_data", d, {64'h3, 64'h2});
        chk("f_r_latency", 128'(lat), 128'(17));

        // Output backpressure with in_valid pulsed during DONE.
        fmode = 2;
        c = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        out_ready = 0;
        send(c);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        d0 = data_out;
        chk("bp_data", d0, ref_block(c, 2));
        repeat (5) begin
            @(negedge clk);
            in_valid = 1;
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            chk("bp_stable", data_out, d0);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_out_valid", 128'(out_valid), 128'(1));
        end
        @(negedge clk);
        in_valid  = 0;
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        chk("bp_release_out_valid", 128'(out_valid), 128'(0));

        // Reset at round 7 discards the block.
        c = {$urandom, $urandom, $urandom, $urandom};
        send(c);
        for (int i = 0; i < 50 && round_idx != 4'd7; i++) @(negedge clk);
        chk("mid_round7", 128'(round_idx), 128'(7));
        rst = 1;
        @(negedge clk);
        chk("mid_rst_state", 128'(fsm_state), 128'(des128_pkg::IDLE));
        chk("mid_rst_lr", {l_out, r_out}, 128'(0));
        chk("mid_rst_round", 128'(round_idx), 128'(0));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        rst = 0;
        c = {$urandom, $urandom, $urandom, $urandom};
        send(c);
        wait_out(0, lat, d);
        chk("post_rst_data", d, ref_block(c, 2));

        // Back-to-back with in_valid held high: accept edges 18 cycles apart.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = ~a;
        cyc = 0; acc = 0; outs = 0;
        @(negedge clk);
        data_in = a; in_valid = 1; out_ready = 1;
        for (int i = 0; i < 120 && outs < 2; i++) begin
            if (i > 0) @(negedge clk);
            cyc++;
            if (acc == 1) data_in = b;
            if (acc == 2) in_valid = 0;
            if (out_valid && out_ready) got[outs++] = data_out;
            if (in_valid && in_ready && acc < 2) acc_cyc[acc++] = cyc;
        end
        in_valid = 0;
        chk("b2b_accepts", 128'(acc), 128'(2));
        chk("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(18));
        chk("b2b_first", got[0], ref_block(a, 2));
        chk("b2b_second", got[1], ref_block(b, 2));

        // Input ignored while busy.
        c = {$urandom, $urandom, $urandom, $urandom};
        send(c);
        repeat (3) @(negedge clk);
        data_in = ~c; in_valid = 1;
        chk("busy_in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        in_valid = 0;
        wait_out(0, lat, d);
        chk("busy_ignore_data", d, ref_block(c, 2));

        // Random blocks, modes, idle gaps and output backpressure.
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            fmode = $urandom_range(0, 2);
            c = {$urandom, $urandom, $urandom, $urandom};
            send(c);
            wait_out(1, lat, d);
            chk("rand_data", d, ref_block(c, fmode));
            chk("rand_latency", 128'(lat), 128'(17));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
